// File: rtl/jtag_scan_ctrl.sv
// JTAG scan controller: resets the TAP, then on each request shifts one IR and one DR scan
// through the TAP. The DR bits that come back on TDO are captured into dr_o.
module jtag_scan_ctrl #(
  parameter int unsigned IR_LEN  = 4,
  parameter int unsigned DR_MAX  = 32,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_i,
  output logic                         ready_o,
  input  logic [IR_LEN-1:0]            ir_i,
  input  logic [$clog2(DR_MAX+1)-1:0]  dr_len_i,
  input  logic [DR_MAX-1:0]            dr_i,
  output logic                         done_o,
  output logic [DR_MAX-1:0]            dr_o,
  output logic                         tck_o,
  output logic                         tms_o,
  output logic                         tdi_o,
  input  logic                         tdo_i
);

  localparam int unsigned LW = $clog2(DR_MAX + 1);
  localparam int unsigned CW = $clog2(DR_MAX + IR_LEN + 8);
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = (DR_MAX > 1) ? $clog2(DR_MAX) : 1;

  localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);
  localparam logic [LW-1:0] DrMaxL  = LW'(DR_MAX);
  localparam logic [CW-1:0] IrLast  = CW'(IR_LEN - 1);

  typedef enum logic [3:0] {
    StTlrRst, StIdle, StIrHdr, StIrShift, StIrTail, StDrHdr, StDrShift, StDrTail, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      bit_q, bit_d;
  logic [DW-1:0]      div_q, div_d;
  logic               phase_q, phase_d;
  logic [IR_LEN-1:0]  ir_q, ir_d;
  logic [DR_MAX-1:0]  drs_q, drs_d;
  logic [LW-1:0]      n_q, n_d;
  logic [DR_MAX-1:0]  dr_q, dr_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;

  logic run, div_wrap, rise, fall;

  assign run      = (state_q != StIdle) && (state_q != StDone);
  assign div_wrap = (div_q == DivLast);
  assign rise     = run && !phase_q && div_wrap;
  assign fall     = run && phase_q && div_wrap;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    div_d   = div_q;
    phase_d = phase_q;
    ir_d    = ir_q;
    drs_d   = drs_q;
    n_d     = n_q;
    dr_d    = dr_q;

    if (run) begin
      if (div_wrap) begin
        div_d   = '0;
        phase_d = ~phase_q;
      end else begin
        div_d = div_q + DW'(1);
      end

      // First captured bit wipes the register so bits above n end up zero.
      if (rise && state_q == StDrShift) begin
        if (bit_q == '0) dr_d = '0;
        dr_d[bit_q[IW-1:0]] = tdo_i;
      end

      if (fall) begin
        bit_d = bit_q + CW'(1);
        case (state_q)
          StTlrRst: begin
            if (bit_q == CW'(5)) begin
              state_d = StIdle;
              bit_d   = '0;
            end
          end
          StIrHdr: begin
            if (bit_q == CW'(3)) begin
              state_d = StIrShift;
              bit_d   = '0;
            end
          end
          StIrShift: begin
            ir_d = ir_q >> 1;
            if (bit_q == IrLast) begin
              state_d = StIrTail;
              bit_d   = '0;
            end
          end
          StIrTail: begin
            if (bit_q == CW'(1)) begin
              bit_d = '0;
              if (n_q == '0) begin
                state_d = StDone;
                dr_d    = '0;
              end else begin
                state_d = StDrHdr;
              end
            end
          end
          StDrHdr: begin
            if (bit_q == CW'(2)) begin
              state_d = StDrShift;
              bit_d   = '0;
            end
          end
          StDrShift: begin
            drs_d = drs_q >> 1;
            if (bit_q == CW'(n_q) - CW'(1)) begin
              state_d = StDrTail;
              bit_d   = '0;
            end
          end
          StDrTail: begin
            if (bit_q == CW'(1)) begin
              state_d = StDone;
              bit_d   = '0;
            end
          end
          default: ;
        endcase
      end
    end else if (req_i) begin
      ir_d    = ir_i;
      drs_d   = dr_i;
      n_d     = (dr_len_i > DrMaxL) ? DrMaxL : dr_len_i;
      state_d = StIrHdr;
      bit_d   = '0;
      div_d   = '0;
      phase_d = 1'b0;
    end else if (state_q == StDone) begin
      state_d = StIdle;
    end
  end

  // TMS/TDI are decoded from the next state so they only move when a new TCK low phase starts.
  always_comb begin
    tms_d = 1'b0;
    tdi_d = 1'b0;
    case (state_d)
      StTlrRst:  tms_d = (bit_d < CW'(5));
      StIrHdr:   tms_d = (bit_d < CW'(2));
      StIrShift: begin
        tms_d = (bit_d == IrLast);
        tdi_d = ir_d[0];
      end
      StIrTail, StDrHdr, StDrTail: tms_d = (bit_d == '0);
      StDrShift: begin
        tms_d = (bit_d == CW'(n_d) - CW'(1));
        tdi_d = drs_d[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StTlrRst;
      bit_q   <= '0;
      div_q   <= '0;
      phase_q <= 1'b0;
      ir_q    <= '0;
      drs_q   <= '0;
      n_q     <= '0;
      dr_q    <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      ir_q    <= ir_d;
      drs_q   <= drs_d;
      n_q     <= n_d;
      dr_q    <= dr_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  assign ready_o = (state_q == StIdle) || (state_q == StDone);
  assign done_o  = (state_q == StDone);
  assign dr_o    = dr_q;
  assign tck_o   = phase_q;
  assign tms_o   = tms_q;
  assign tdi_o   = tdi_q;

endmodule

// File: doc/jtag_scan_ctrl.md
JTAG_SCAN_CTRL -- requirements
Module: jtag_scan_ctrl

Interface
REQ-001 Parameter: IR_LEN, default 4, instruction register length in bits (2..8).
REQ-002 Parameter: DR_MAX, default 32, maximum data register scan length in bits.
REQ-003 Parameter: CLK_DIV, default 4, clk_i cycles per TCK phase (>=1); one TCK period is 2*CLK_DIV clk_i cycles.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk_i  in  1  system clock; the only clock.
REQ-006 rst_i  in  1  reset: asynchronous assert, active-high.
REQ-007 req_i  in  1  scan request valid.
REQ-008 ready_o  out  1  block idle and able to accept a request.
REQ-009 ir_i  in  IR_LEN  instruction to load, shifted LSB first.
REQ-010 dr_len_i  in  $clog2(DR_MAX+1)  DR scan length in bits.
REQ-011 dr_i  in  DR_MAX  data to shift in, LSB first.
REQ-012 done_o  out  1  single-cycle completion pulse.
REQ-013 dr_o  out  DR_MAX  captured TDO bits of the last DR scan.
REQ-014 tck_o / tms_o / tdi_o  out  1 each  JTAG drive to TAP.
REQ-015 tdo_i  in  1  JTAG data returned from TAP.

Function
REQ-016 TCK cycle: tck_o low for CLK_DIV clk_i cycles, then high for CLK_DIV cycles. tms_o and tdi_o update only at the start of the low phase. tdo_i is sampled on the clk_i edge that drives tck_o high.
REQ-017 FSM states: TLR_RST, IDLE, IR_HDR, IR_SHIFT, IR_TAIL, DR_HDR, DR_SHIFT, DR_TAIL, DONE.
REQ-018 TLR_RST: 5 TCKs with TMS=1, then 1 TCK with TMS=0 (TAP to Run-Test/Idle), then go to IDLE.
REQ-019 IDLE: ready_o=1, tck_o=0, tms_o=0, tdi_o=0. A request is accepted when req_i&ready_o. ir_i, dr_i and dr_len_i are latched on acceptance, and ready_o drops the next cycle.
REQ-020 req_i while ready_o=0 is ignored and causes no queuing.
REQ-021 IR_HDR: TMS sequence 1,1,0,0 (4 TCKs).
REQ-022 IR_SHIFT: IR_LEN TCKs.
  - tdi = ir bit k on the k-th TCK.
  - TMS=0, except TMS=1 on the last bit.
REQ-023 IR_TAIL: TMS 1,0 (Update-IR, Run-Test/Idle).
REQ-024 DR_HDR: TMS 1,0,0 (3 TCKs).
REQ-025 DR_SHIFT: n TCKs, where n is the effective length.
  - tdi = dr bit k on the k-th TCK.
  - TMS=1 only on the last bit.
  - tdo sampled on TCK k is written to dr_o[k].
REQ-026 DR_TAIL: TMS 1,0.
REQ-027 DONE:
  - done_o=1 for exactly one cycle after the final TCK high phase ends.
  - ready_o=1 in that same cycle.
  - FSM is in IDLE the next cycle.
REQ-028 Effective length n = min(dr_len_i, DR_MAX). If dr_len_i>DR_MAX, the scan is clamped to DR_MAX bits.
REQ-029 If dr_len_i=0: the DR phases are skipped, the FSM goes IR_TAIL -> DONE, and dr_o is cleared to 0.
REQ-030 dr_o bits [DR_MAX-1:n] SHALL be 0 after each DR scan. dr_o is updated only in DR_SHIFT and otherwise holds its value.
REQ-031 tdi_o SHALL be 0 outside IR_SHIFT/DR_SHIFT.
REQ-032 Total TCK count per request:
  - (4+IR_LEN+2) + (3+n+2) when n>0.
  - 4+IR_LEN+2 when n=0.

Reset
REQ-033 Reset values while rst_i=1:
  - tck_o=0, tms_o=1, tdi_o=0.
  - ready_o=0, done_o=0, dr_o=0.
  - FSM in TLR_RST, TCK divider and bit counters 0.
REQ-034 Reset asserted mid-scan SHALL abort immediately. No done_o is generated. After release, the full TLR_RST sequence runs before ready_o=1.
REQ-035 After reset release, ready_o SHALL rise exactly 6*2*CLK_DIV clk_i cycles later.

Verification
REQ-036 Reset, CLK_DIV=4 -> 5 TCKs with tms_o=1 then 1 with tms_o=0; ready_o=1 48 cycles after release.
REQ-037 IR_LEN=4, ir_i=4'hA, dr_len_i=8, dr_i=8'h5A, TAP model returning 8'hC3 -> 23 TCKs.
  - tdi in IR_SHIFT: 0,1,0,1.
  - tdi in DR_SHIFT: 0,1,0,1,1,0,1,0.
  - dr_o=32'h000000C3, one done_o pulse.
REQ-038 dr_len_i=0, ir_i=4'h3 -> 10 TCKs, dr_o=0, done_o pulse, no Capture-DR visited in the TAP model.
REQ-039 dr_len_i=40 (DR_MAX=32), dr_i=32'hFFFFFFFF -> exactly 32 DR shift TCKs, TMS=1 on the 32nd.
REQ-040 req_i held high continuously -> back-to-back scans separated by exactly one IDLE/DONE cycle. No request is accepted while ready_o=0.
REQ-041 rst_i pulsed during DR_SHIFT bit 3 -> outputs reset asynchronously, no done_o, TLR_RST sequence repeats, then ready_o=1.
